// File: rtl/id_stage_pipe.sv
// RV32I decode stage: combinational decode, operand forwarding, load-use stall,
// optional in-decode branch resolution, and a valid/ready output register.
package id_stage_pkg;
    typedef enum logic [5:0] {
        OPT_NOP = 6'd0, OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR,
        OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU,
        OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU, OPT_SB, OPT_SH, OPT_SW,
        OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI,
        OPT_SLLI, OPT_SRLI, OPT_SRAI,
        OPT_ADD, OPT_SUB, OPT_SLL, OPT_SLT, OPT_SLTU, OPT_XOR,
        OPT_SRL, OPT_SRA, OPT_OR, OPT_AND,
        OPT_FENCE, OPT_ECALL, OPT_EBREAK
    } opt_e;

    typedef enum logic [2:0] {FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
endpackage

module id_stage_pipe
    import id_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int OPT_W        = 6,
    parameter int BRANCH_IN_ID = 1,
    parameter int FWD_EN       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [31:0]       inst_i,
    output logic              re1_o,
    output logic              re2_o,
    output logic [REG_AW-1:0] raddr1_o,
    output logic [REG_AW-1:0] raddr2_o,
    input  logic [XLEN-1:0]   rdata1_i,
    input  logic [XLEN-1:0]   rdata2_i,
    input  logic              ex_we,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic              flush_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   pc_o,
    output logic [6:0]        opcode_o,
    output logic [OPT_W-1:0]  opt_o,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o,
    output logic              we_o,
    output logic [REG_AW-1:0] waddr_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [4:0]        shamt_o,
    output logic              illegal_o,
    output logic              branch_to_if,
    output logic [XLEN-1:0]   jump_addr_to_if
);
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [6:0]        opcode;
        logic [OPT_W-1:0]  opt;
        logic [XLEN-1:0]   rdata1;
        logic [XLEN-1:0]   rdata2;
        logic              we;
        logic [REG_AW-1:0] waddr;
        logic [XLEN-1:0]   imm;
        logic [4:0]        shamt;
        logic              illegal;
    } dec_t;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    opt_e            opt;
    fmt_e            fmt;
    logic            we, illegal, use_shamt;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm, op1, op2, target;
    logic            taken, stall, accept;
    dec_t            dec_d, out_q;

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        opt       = OPT_NOP;
        fmt       = FMT_NONE;
        we        = 1'b0;
        illegal   = 1'b0;
        use_shamt = 1'b0;
        case (opcode)
            OP_LUI:   begin opt = OPT_LUI;   fmt = FMT_U; we = 1'b1; end
            OP_AUIPC: begin opt = OPT_AUIPC; fmt = FMT_U; we = 1'b1; end
            OP_JAL:   begin opt = OPT_JAL;   fmt = FMT_J; we = 1'b1; end
            OP_JALR:  begin opt = OPT_JALR;  fmt = FMT_I; we = 1'b1; illegal = (f3 != 3'd0); end
            OP_BRANCH: begin
                fmt = FMT_B;
                case (f3)
                    3'd0: opt = OPT_BEQ;   3'd1: opt = OPT_BNE;
                    3'd4: opt = OPT_BLT;   3'd5: opt = OPT_BGE;
                    3'd6: opt = OPT_BLTU;  3'd7: opt = OPT_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                fmt = FMT_I; we = 1'b1;
                case (f3)
                    3'd0: opt = OPT_LB;  3'd1: opt = OPT_LH;  3'd2: opt = OPT_LW;
                    3'd4: opt = OPT_LBU; 3'd5: opt = OPT_LHU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                fmt = FMT_S;
                case (f3)
                    3'd0: opt = OPT_SB; 3'd1: opt = OPT_SH; 3'd2: opt = OPT_SW;
                    default: illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                fmt = FMT_I; we = 1'b1;
                case (f3)
                    3'd0: opt = OPT_ADDI;  3'd2: opt = OPT_SLTI; 3'd3: opt = OPT_SLTIU;
                    3'd4: opt = OPT_XORI;  3'd6: opt = OPT_ORI;  3'd7: opt = OPT_ANDI;
                    3'd1: begin opt = OPT_SLLI; use_shamt = 1'b1; illegal = (f7 != 7'h00); end
                    default: begin
                        use_shamt = 1'b1;
                        if (f7 == 7'h00)      opt = OPT_SRLI;
                        else if (f7 == 7'h20) opt = OPT_SRAI;
                        else                  illegal = 1'b1;
                    end
                endcase
            end
            OP_REG: begin
                fmt = FMT_R; we = 1'b1;
                case ({f7, f3})
                    {7'h00, 3'd0}: opt = OPT_ADD;  {7'h20, 3'd0}: opt = OPT_SUB;
                    {7'h00, 3'd1}: opt = OPT_SLL;  {7'h00, 3'd2}: opt = OPT_SLT;
                    {7'h00, 3'd3}: opt = OPT_SLTU; {7'h00, 3'd4}: opt = OPT_XOR;
                    {7'h00, 3'd5}: opt = OPT_SRL;  {7'h20, 3'd5}: opt = OPT_SRA;
                    {7'h00, 3'd6}: opt = OPT_OR;   {7'h00, 3'd7}: opt = OPT_AND;
                    default: illegal = 1'b1;
                endcase
            end
            OP_FENCE: begin opt = OPT_FENCE; illegal = (f3 != 3'd0); end
            OP_SYSTEM: begin
                if (inst_i == 32'h0000_0073)      opt = OPT_ECALL;
                else if (inst_i == 32'h0010_0073) opt = OPT_EBREAK;
                else                              illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            opt       = OPT_NOP;
            fmt       = FMT_NONE;
            we        = 1'b0;
            use_shamt = 1'b0;
        end
    end

    always_comb begin
        case (fmt)
            FMT_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            FMT_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FMT_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            FMT_U:   imm32 = {inst_i[31:12], 12'd0};
            FMT_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end
    assign imm = XLEN'($signed(imm32));

    assign re1_o    = in_valid & (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B);
    assign re2_o    = in_valid & (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B);
    assign raddr1_o = in_valid ? REG_AW'(inst_i[19:15]) : '0;
    assign raddr2_o = in_valid ? REG_AW'(inst_i[24:20]) : '0;

    // Forwarding priority: ex (non-load result) over mem over regfile; x0 is hardwired zero.
    always_comb begin
        op1 = rdata1_i;
        if (raddr1_o == '0) op1 = '0;
        else if (FWD_EN != 0 && ex_we && !ex_load && ex_waddr == raddr1_o) op1 = ex_wdata;
        else if (FWD_EN != 0 && mem_we && mem_waddr == raddr1_o) op1 = mem_wdata;
        if (!re1_o) op1 = '0;
    end

    always_comb begin
        op2 = rdata2_i;
        if (raddr2_o == '0) op2 = '0;
        else if (FWD_EN != 0 && ex_we && !ex_load && ex_waddr == raddr2_o) op2 = ex_wdata;
        else if (FWD_EN != 0 && mem_we && mem_waddr == raddr2_o) op2 = mem_wdata;
        if (!re2_o) op2 = '0;
    end

    assign stall = (FWD_EN != 0) & ex_we & ex_load & (ex_waddr != '0) &
                   ((re1_o & (ex_waddr == raddr1_o)) | (re2_o & (ex_waddr == raddr2_o)));
    assign in_ready = (~out_valid | out_ready) & ~stall & ~flush_i;
    assign accept   = in_valid & in_ready;

    always_comb begin
        case (opt)
            OPT_BEQ:  taken = (op1 == op2);
            OPT_BNE:  taken = (op1 != op2);
            OPT_BLT:  taken = ($signed(op1) < $signed(op2));
            OPT_BGE:  taken = ($signed(op1) >= $signed(op2));
            OPT_BLTU: taken = (op1 < op2);
            OPT_BGEU: taken = (op1 >= op2);
            OPT_JAL, OPT_JALR: taken = 1'b1;
            default:  taken = 1'b0;
        endcase
        target = pc_i + imm;
        if (opt == OPT_JALR) target = (op1 + imm) & ~XLEN'(1);
    end

    assign branch_to_if    = (BRANCH_IN_ID != 0) & accept & taken;
    assign jump_addr_to_if = branch_to_if ? target : '0;

    always_comb begin
        dec_d         = '0;
        dec_d.pc      = pc_i;
        dec_d.opcode  = opcode;
        dec_d.opt     = OPT_W'(opt);
        dec_d.rdata1  = op1;
        dec_d.rdata2  = op2;
        dec_d.we      = we;
        dec_d.waddr   = we ? REG_AW'(inst_i[11:7]) : '0;
        dec_d.imm     = imm;
        dec_d.shamt   = use_shamt ? inst_i[24:20] : 5'd0;
        dec_d.illegal = illegal;
    end

    // NOTE: sequential state uses non-blocking assignments; the all-zero image doubles as the NOP encoding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_q     <= dec_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign pc_o      = out_q.pc;
    assign opcode_o  = out_q.opcode;
    assign opt_o     = out_q.opt;
    assign rdata1_o  = out_q.rdata1;
    assign rdata2_o  = out_q.rdata2;
    assign we_o      = out_q.we;
    assign waddr_o   = out_q.waddr;
    assign imm_o     = out_q.imm;
    assign shamt_o   = out_q.shamt;
    assign illegal_o = out_q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a table of decode/forward/redirect vectors
// applied back-to-back, then hand sequences for stall, backpressure, flush and reset.
module tb_id_stage_pipe;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] pc_i, inst_i;
    logic        re1_o, re2_o;
    logic [4:0]  raddr1_o, raddr2_o;
    logic [31:0] rdata1_i, rdata2_i;
    logic        ex_we, ex_load;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        flush_i, out_valid, out_ready;
    logic [31:0] pc_o;
    logic [6:0]  opcode_o;
    logic [5:0]  opt_o;
    logic [31:0] rdata1_o, rdata2_o;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] imm_o;
    logic [4:0]  shamt_o;
    logic        illegal_o, branch_to_if;
    logic [31:0] jump_addr_to_if;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i), .re1_o(re1_o), .re2_o(re2_o),
        .raddr1_o(raddr1_o), .raddr2_o(raddr2_o), .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
        .ex_we(ex_we), .ex_load(ex_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
        .pc_o(pc_o), .opcode_o(opcode_o), .opt_o(opt_o), .rdata1_o(rdata1_o), .rdata2_o(rdata2_o),
        .we_o(we_o), .waddr_o(waddr_o), .imm_o(imm_o), .shamt_o(shamt_o), .illegal_o(illegal_o),
        .branch_to_if(branch_to_if), .jump_addr_to_if(jump_addr_to_if)
    );

    typedef struct {
        string       name;
        logic [31:0] pc, inst, rd1, rd2;
        logic        ex_we;
        logic [4:0]  ex_waddr;
        logic [31:0] ex_wdata;
        logic        mem_we;
        logic [4:0]  mem_waddr;
        logic [31:0] mem_wdata;
        opt_e        e_opt;
        logic [31:0] e_imm;
        logic        e_we;
        logic [4:0]  e_waddr, e_shamt;
        logic        e_ill;
        logic [31:0] e_r1, e_r2;
        logic        e_re1, e_re2, e_br;
        logic [31:0] e_ja;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; pc_i = '0; inst_i = '0; rdata1_i = '0; rdata2_i = '0;
        ex_we = 1'b0; ex_load = 1'b0; ex_waddr = '0; ex_wdata = '0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0; flush_i = 1'b0; out_ready = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".opt"}, opt_o, OPT_NOP);
        check({tag, ".opcode"}, opcode_o, 0);
        check({tag, ".pc"}, pc_o, 0);
        check({tag, ".imm"}, imm_o, 0);
        check({tag, ".rdata"}, {rdata1_o, rdata2_o}, 0);
        check({tag, ".we_waddr"}, {we_o, waddr_o, shamt_o, illegal_o}, 0);
    endtask

    initial begin
        //          name     pc            inst          rd1           rd2         exwe exwa exwd        mwe mwa mwd          opt         imm           we wa  sh   ill r1            r2           re1 re2 br ja
        vecs[0]  = '{"addi",  32'h0,       32'h00500093, 32'hAAAA,     32'h0,      0, 0, 32'h0,       0, 0, 32'h0,  OPT_ADDI,  32'h5,        1, 1,  0,  0,  32'h0,        32'h0,       1, 0, 0, 32'h0};
        vecs[1]  = '{"add_ex", 32'h4,      32'h00108133, 32'd99,       32'd99,     1, 1, 32'd5,       0, 0, 32'h0,  OPT_ADD,   32'h0,        1, 2,  0,  0,  32'd5,        32'd5,       1, 1, 0, 32'h0};
        vecs[2]  = '{"sub_pri", 32'h8,     32'h402081B3, 32'h1234,     32'h9999,   1, 2, 32'h11,      1, 2, 32'h22, OPT_SUB,   32'h0,        1, 3,  0,  0,  32'h1234,     32'h11,      1, 1, 0, 32'h0};
        vecs[3]  = '{"add_mem", 32'hC,     32'h00208233, 32'h1,        32'h55,     1, 5, 32'hEE,      1, 1, 32'h77, OPT_ADD,   32'h0,        1, 4,  0,  0,  32'h77,       32'h55,      1, 1, 0, 32'h0};
        vecs[4]  = '{"beq_t", 32'h100,     32'hFE628CE3, 32'd7,        32'd7,      0, 0, 32'h0,       0, 0, 32'h0,  OPT_BEQ,   32'hFFFFFFF8, 0, 0,  0,  0,  32'd7,        32'd7,       1, 1, 1, 32'hF8};
        vecs[5]  = '{"beq_nt", 32'h100,    32'hFE628CE3, 32'd7,        32'd8,      0, 0, 32'h0,       0, 0, 32'h0,  OPT_BEQ,   32'hFFFFFFF8, 0, 0,  0,  0,  32'd7,        32'd8,       1, 1, 0, 32'h0};
        vecs[6]  = '{"blt_t", 32'h200,     32'h0062C863, 32'hFFFFFFFF, 32'd1,      0, 0, 32'h0,       0, 0, 32'h0,  OPT_BLT,   32'h10,       0, 0,  0,  0,  32'hFFFFFFFF, 32'd1,       1, 1, 1, 32'h210};
        vecs[7]  = '{"bltu_nt", 32'h200,   32'h0062E863, 32'hFFFFFFFF, 32'd1,      0, 0, 32'h0,       0, 0, 32'h0,  OPT_BLTU,  32'h10,       0, 0,  0,  0,  32'hFFFFFFFF, 32'd1,       1, 1, 0, 32'h0};
        vecs[8]  = '{"jalr_wrap", 32'h300, 32'h003280E7, 32'hFFFFFFFF, 32'h0,      0, 0, 32'h0,       0, 0, 32'h0,  OPT_JALR,  32'h3,        1, 1,  0,  0,  32'hFFFFFFFF, 32'h0,       1, 0, 1, 32'h2};
        vecs[9]  = '{"jal", 32'h1000,      32'h001000EF, 32'h5,        32'h5,      0, 0, 32'h0,       0, 0, 32'h0,  OPT_JAL,   32'h800,      1, 1,  0,  0,  32'h0,        32'h0,       0, 0, 1, 32'h1800};
        vecs[10] = '{"lui", 32'h1004,      32'h123452B7, 32'h5,        32'h5,      0, 0, 32'h0,       0, 0, 32'h0,  OPT_LUI,   32'h12345000, 1, 5,  0,  0,  32'h0,        32'h0,       0, 0, 0, 32'h0};
        vecs[11] = '{"srai", 32'h1008,     32'h41F45393, 32'h80000000, 32'h0,      0, 0, 32'h0,       0, 0, 32'h0,  OPT_SRAI,  32'h41F,      1, 7,  31, 0,  32'h80000000, 32'h0,       1, 0, 0, 32'h0};
        vecs[12] = '{"sw_neg", 32'h100C,   32'hFE322E23, 32'h1000,     32'hABCD,   0, 0, 32'h0,       0, 0, 32'h0,  OPT_SW,    32'hFFFFFFFC, 0, 0,  0,  0,  32'h1000,     32'hABCD,    1, 1, 0, 32'h0};
        vecs[13] = '{"ill_ff", 32'h1010,   32'hFFFFFFFF, 32'h3,        32'h3,      0, 0, 32'h0,       0, 0, 32'h0,  OPT_NOP,   32'h0,        0, 0,  0,  1,  32'h0,        32'h0,       0, 0, 0, 32'h0};
        vecs[14] = '{"ill_f7", 32'h1014,   32'h02108133, 32'h3,        32'h3,      0, 0, 32'h0,       0, 0, 32'h0,  OPT_NOP,   32'h0,        0, 0,  0,  1,  32'h0,        32'h0,       0, 0, 0, 32'h0};
        vecs[15] = '{"add_x0", 32'h1018,   32'h00000133, 32'h1111,     32'h1111,   1, 0, 32'hDEAD,    1, 0, 32'hBEEF, OPT_ADD, 32'h0,        1, 2,  0,  0,  32'h0,        32'h0,       1, 1, 0, 32'h0};

        idle_inputs();
        rst = 1'b1;
        #3;
        check_regs_zero("reset_init");
        next_cycle();
        rst = 1'b0;

        // Table: one vector per cycle, out_ready held high, so each must be accepted back-to-back.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; pc_i = vecs[i].pc; inst_i = vecs[i].inst;
            rdata1_i = vecs[i].rd1; rdata2_i = vecs[i].rd2;
            ex_we = vecs[i].ex_we; ex_load = 1'b0; ex_waddr = vecs[i].ex_waddr; ex_wdata = vecs[i].ex_wdata;
            mem_we = vecs[i].mem_we; mem_waddr = vecs[i].mem_waddr; mem_wdata = vecs[i].mem_wdata;
            #2;
            check({vecs[i].name, ".in_ready"}, in_ready, 1);
            check({vecs[i].name, ".re"}, {re1_o, re2_o}, {vecs[i].e_re1, vecs[i].e_re2});
            check({vecs[i].name, ".raddr1"}, raddr1_o, vecs[i].inst[19:15]);
            check({vecs[i].name, ".raddr2"}, raddr2_o, vecs[i].inst[24:20]);
            check({vecs[i].name, ".branch"}, branch_to_if, vecs[i].e_br);
            check({vecs[i].name, ".jump_addr"}, jump_addr_to_if, vecs[i].e_ja);
            next_cycle();
            check({vecs[i].name, ".out_valid"}, out_valid, 1);
            check({vecs[i].name, ".pc"}, pc_o, vecs[i].pc);
            check({vecs[i].name, ".opcode"}, opcode_o, vecs[i].inst[6:0]);
            check({vecs[i].name, ".opt"}, opt_o, vecs[i].e_opt);
            check({vecs[i].name, ".imm"}, imm_o, vecs[i].e_imm);
            check({vecs[i].name, ".rdata1"}, rdata1_o, vecs[i].e_r1);
            check({vecs[i].name, ".rdata2"}, rdata2_o, vecs[i].e_r2);
            check({vecs[i].name, ".we"}, we_o, vecs[i].e_we);
            check({vecs[i].name, ".waddr"}, waddr_o, vecs[i].e_waddr);
            check({vecs[i].name, ".shamt"}, shamt_o, vecs[i].e_shamt);
            check({vecs[i].name, ".illegal"}, illegal_o, vecs[i].e_ill);
        end

        // Load-use on rs2: SW x3,0(x4) while ex holds a load to x3.
        idle_inputs();
        in_valid = 1'b1; pc_i = 32'h2000; inst_i = 32'h00322023; rdata1_i = 32'h40; rdata2_i = 32'h9;
        ex_we = 1'b1; ex_load = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h1;
        #2;
        check("lu.stall_ready", in_ready, 0);
        next_cycle();
        check("lu.bubble", out_valid, 0);
        ex_we = 1'b0; ex_load = 1'b0;
        #2;
        check("lu.release_ready", in_ready, 1);
        next_cycle();
        check("lu.sw_valid", out_valid, 1);
        check("lu.sw_opt", opt_o, OPT_SW);
        check("lu.sw_rdata", {rdata1_o, rdata2_o}, {32'h40, 32'h9});

        // Load-use on rs1 of a taken branch: no redirect while stalled, redirect on the later accept.
        idle_inputs();
        in_valid = 1'b1; pc_i = 32'h100; inst_i = 32'hFE628CE3; rdata1_i = 32'd7; rdata2_i = 32'd7;
        ex_we = 1'b1; ex_load = 1'b1; ex_waddr = 5'd5;
        #2;
        check("lu_br.stall_ready", in_ready, 0);
        check("lu_br.no_redirect", branch_to_if, 0);
        next_cycle();
        check("lu_br.bubble", out_valid, 0);
        ex_we = 1'b0; ex_load = 1'b0;
        #2;
        check("lu_br.redirect", branch_to_if, 1);
        check("lu_br.target", jump_addr_to_if, 32'hF8);
        next_cycle();
        check("lu_br.valid", out_valid, 1);

        // Backpressure then flush.
        idle_inputs();
        in_valid = 1'b1; pc_i = 32'h3000; inst_i = 32'h123452B7;
        next_cycle();
        check("bp.lui_valid", out_valid, 1);
        out_ready = 1'b0; inst_i = 32'h00500093; pc_i = 32'h3004;
        #2;
        check("bp.in_ready", in_ready, 0);
        next_cycle();
        check("bp.hold_valid", out_valid, 1);
        check("bp.hold_imm", imm_o, 32'h12345000);
        check("bp.hold_opt", opt_o, OPT_LUI);
        check("bp.hold_pc", pc_o, 32'h3000);
        flush_i = 1'b1; inst_i = 32'h001000EF; pc_i = 32'h1000;
        #2;
        check("flush.no_redirect", branch_to_if, 0);
        check("flush.in_ready", in_ready, 0);
        next_cycle();
        check("flush.out_valid", out_valid, 0);

        // Idle input: no read addresses and no redirect even for a JAL word.
        idle_inputs();
        inst_i = 32'hFE628CE3;
        #2;
        check("idle.raddr", {raddr1_o, raddr2_o}, 0);
        inst_i = 32'h001000EF;
        #1;
        check("idle.no_redirect", branch_to_if, 0);
        next_cycle();
        check("idle.out_valid", out_valid, 0);

        // Asynchronous reset in the middle of a stalled, backpressured cycle.
        in_valid = 1'b1; pc_i = 32'h4000; inst_i = 32'h123452B7;
        next_cycle();
        check("ar.pre_valid", out_valid, 1);
        out_ready = 1'b0; inst_i = 32'h00322023; ex_we = 1'b1; ex_load = 1'b1; ex_waddr = 5'd3;
        #2;
        rst = 1'b1;
        #1;
        check_regs_zero("ar.mid");
        next_cycle();
        check("ar.held_valid", out_valid, 0);
        rst = 1'b0;
        idle_inputs();
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, parametrised RV32I decode stage between if_id and ex.
- Decodes each instruction: opcode/opt class, immediate, shamt, register read enables, write-back target.
- Forwards operands from the ex and mem stages, detects load-use hazards and stalls on them.
- Optionally resolves branches and jumps in decode and redirects if.
- Inputs and outputs use a valid/ready handshake; the decode result is held in an output register.

Parameters:
- XLEN, 32, datapath and address width.
- REG_AW, 5, register address width.
- OPT_W, 6, width of opt_o; codes are the team's existing Opt* set.
- BRANCH_IN_ID, 1:
  - 1: branches and jumps are resolved here and redirect if.
  - 0: no redirect is generated; ex resolves them.
- FWD_EN, 1:
  - 1: ex/mem forwarding and load-use stall are enabled.
  - 0: regfile data is passed through unchanged and no hazard stall is generated.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  if_id holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- pc_i  in  XLEN  instruction address.
- inst_i  in  32  instruction word.
- re1_o, re2_o  out  1  regfile read enables (combinational).
- raddr1_o, raddr2_o  out  REG_AW  regfile read addresses (combinational).
- rdata1_i, rdata2_i  in  XLEN  regfile read data.
- ex_we, ex_load  in  1  ex-stage instruction writes a register / is a load.
- ex_waddr  in  REG_AW  ex-stage destination register.
- ex_wdata  in  XLEN  ex-stage result.
- mem_we  in  1  mem-stage instruction writes a register.
- mem_waddr  in  REG_AW  mem-stage destination register.
- mem_wdata  in  XLEN  mem-stage result.
- flush_i  in  1  kill the current decode and the output register.
- out_valid  out  1  output register holds a valid decoded instruction.
- out_ready  in  1  ex consumes the output this cycle.
- pc_o  out  XLEN  registered PC.
- opcode_o  out  7  registered opcode.
- opt_o  out  OPT_W  registered operation code.
- rdata1_o, rdata2_o  out  XLEN  registered forwarded operands.
- we_o  out  1  registered write-back enable.
- waddr_o  out  REG_AW  registered destination register.
- imm_o  out  XLEN  registered sign-extended immediate.
- shamt_o  out  5  registered shift amount.
- illegal_o  out  1  registered illegal-instruction flag.
- branch_to_if  out  1  redirect pulse to if (combinational).
- jump_addr_to_if  out  XLEN  redirect target (combinational).

Behaviour:
- Reset (asynchronous, any time, including mid-stall):
  - out_valid=0 and every registered output is 0.
  - opt_o and opcode_o take the NOP codes; raddr/waddr are 0.
- Decode is combinational from inst_i.
  - Immediate formats are I/S/B/U/J, sign-extended to XLEN.
  - re1_o/re2_o follow the instruction format: LUI, AUIPC and JAL read neither register.
  - raddr1_o=inst[19:15] and raddr2_o=inst[24:20] whenever in_valid=1; otherwise they are 0.
  - Unknown opcode, funct3 or funct7 gives opt=NOP, we=0, illegal=1.
- Operand forwarding (FWD_EN=1), evaluated per source register:
  - Priority: ex (ex_we, not ex_load) > mem > regfile.
  - A source address of 0 always gives 0 and is never forwarded.
- Load-use stall:
  - stall = FWD_EN & ex_we & ex_load & ex_waddr≠0 & ((re1_o & ex_waddr==raddr1_o) | (re2_o & ex_waddr==raddr2_o)).
- in_ready = (~out_valid | out_ready) & ~stall & ~flush_i.
- Accept event: in_valid & in_ready.
- Register update on each clock edge:
  - flush_i=1: out_valid←0; all other registered outputs are don't-care but are written to NOP values.
  - Else accept: the register loads the decode result and out_valid←1.
  - Else if out_ready=1: out_valid←0. This inserts a bubble during a stall.
  - Else: hold.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle when out_ready=1 and there is no hazard.
- Redirect (BRANCH_IN_ID=1) is asserted only in the cycle of an accept event; it is never asserted when stalled, flushed or idle.
  - JAL: target = pc_i+imm.
  - JALR: target = (fwd_rs1+imm) & ~1.
  - Taken branch: target = pc_i+imm. Compare on forwarded operands; BLT/BGE are signed, BLTU/BGEU are unsigned.
  - Not-taken branch or no redirect: branch_to_if=0 and jump_addr_to_if=0.
  - Address arithmetic wraps modulo 2^XLEN.
- BRANCH_IN_ID=0: branch_to_if is held at 0.
- Simultaneous events:
  - flush_i dominates accept and out_ready.
  - stall together with out_ready=1 drains the output and shows a bubble next cycle.

Test Plan:
- Reset: rst=1 mid-stream, asynchronous to clk -> out_valid=0 immediately, opt_o=NOP, and every registered output is 0.
- Back-to-back throughput:
  - Stimulus: ADDI x1,x0,5 followed by ADD x2,x1,x1, out_ready=1, with ex_we=1, ex_waddr=1, ex_wdata=5 on the ADD cycle.
  - Required: ADD rdata1_o=rdata2_o=5, out_valid on consecutive cycles.
- Load-use:
  - Stimulus: ex_load=1, ex_waddr=3, with SW x3,0(x4) at the input.
  - Required: in_ready=0 for 1 cycle and a bubble out_valid=0 that cycle; SW is accepted the following cycle once ex_load=0.
- Branch:
  - Stimulus: BEQ at pc=0x100, imm=-8, rdata1=rdata2=7.
  - Required: branch_to_if=1 and jump_addr=0xF8 in the accept cycle; with rdata2=8, branch_to_if=0.
- JALR wrap:
  - Stimulus: rs1=0xFFFFFFFF, imm=3.
  - Required: jump_addr=0x00000002.
- Flush and backpressure:
  - Stimulus: out_ready=0 while holding LUI x5,0x12345.
  - Required: outputs hold with imm_o=0x12345000 and in_ready=0; asserting flush_i gives out_valid=0 next cycle and no redirect.
  - Stimulus: illegal word 0xFFFFFFFF.
  - Required: illegal_o=1, opt_o=NOP, we_o=0.
